// File: rtl/zipdbg_slave_pkg.sv
// Shared definitions for the ZipCPU debug-port responder.
//   - Control register bit positions (read/write view at address 6'h00)
//   - Address decode constants
//   - Responder state encoding
//   - Helper that assembles the control-register read word
package zipdbg_slave_pkg;

  // Control register bit positions
  localparam int unsigned CTRL_HALT     = 0;
  localparam int unsigned CTRL_STEP     = 1;
  localparam int unsigned CTRL_RESET    = 2;
  localparam int unsigned CTRL_CLRCACHE = 3;
  localparam int unsigned CTRL_DSTALL   = 5;
  localparam int unsigned CTRL_BREAK    = 6;
  localparam int unsigned CTRL_CC_LSB   = 7;
  localparam int unsigned CTRL_CC_MSB   = 9;

  // Address decode
  localparam logic [5:0]  ADDR_CTRL       = 6'h00;
  localparam int unsigned ADDR_REGWIN_BIT = 5;

  // Responder states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // Control read word; step and pulse bits always read back as zero.
  function automatic logic [31:0] ctrl_word(input logic       halt,
                                            input logic       dstall,
                                            input logic       brk,
                                            input logic [2:0] cc);
    logic [31:0] w;
    w                          = '0;
    w[CTRL_HALT]               = halt;
    w[CTRL_DSTALL]             = dstall;
    w[CTRL_BREAK]              = brk;
    w[CTRL_CC_MSB:CTRL_CC_LSB] = cc;
    return w;
  endfunction

endpackage

// File: rtl/zipdbg_slave.sv
// Wishbone pipelined responder for the ZipCPU core debug interface.
// A host bridge uses it to halt/step/reset the CPU, clear caches, and
// read/write CPU registers through the core's debug register ports.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_wb_*                  Wishbone request (cyc/stb/we/addr/data/sel)
//   o_wb_stall/ack/data     Wishbone response
//   o_halt                  CPU halt request
//   o_clear_cache           one-cycle cache clear pulse
//   o_cpu_reset             one-cycle CPU reset pulse
//   o_dbg_we/wreg/data      debug register write port (held until !i_dbg_stall)
//   o_dbg_rreg              debug register read index
//   i_dbg_stall             core cannot accept a debug write
//   i_dbg_reg               read data for o_dbg_rreg
//   i_dbg_cc, i_break       core status reported in the control register
module zipdbg_slave
  import zipdbg_slave_pkg::*;
#(
  parameter logic        OPT_START_HALTED = 1'b1,
  parameter int unsigned OPT_DBGWAIT      = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [5:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_halt,
  output logic        o_clear_cache,
  output logic        o_cpu_reset,
  output logic        o_dbg_we,
  output logic [4:0]  o_dbg_wreg,
  output logic [31:0] o_dbg_data,
  output logic [4:0]  o_dbg_rreg,
  input  logic        i_dbg_stall,
  input  logic [31:0] i_dbg_reg,
  input  logic [2:0]  i_dbg_cc,
  input  logic        i_break
);

  // Read wait counter counts down to zero, so the load value is one less
  // than the number of cycles to wait.
  localparam logic [1:0] WAIT_LOAD = 2'(OPT_DBGWAIT - 1);

  state_t      state_q,       state_d;
  logic        halt_q,        halt_d;
  logic        step_q,        step_d;
  logic        cpu_reset_q,   cpu_reset_d;
  logic        clear_cache_q, clear_cache_d;
  logic        dbg_we_q,      dbg_we_d;
  logic [4:0]  dbg_wreg_q,    dbg_wreg_d;
  logic [31:0] dbg_data_q,    dbg_data_d;
  logic [4:0]  dbg_rreg_q,    dbg_rreg_d;
  logic [31:0] wb_data_q,     wb_data_d;
  logic [1:0]  wait_cnt_q,    wait_cnt_d;

  logic req;
  logic ctrl_sel;
  logic unused_sel;

  assign req        = i_wb_cyc && i_wb_stb;
  assign ctrl_sel   = (i_wb_addr == ADDR_CTRL);
  assign unused_sel = ^i_wb_sel[3:1];

  always_comb begin
    state_d       = state_q;
    halt_d        = halt_q;
    step_d        = 1'b0;
    cpu_reset_d   = 1'b0;
    clear_cache_d = 1'b0;
    dbg_we_d      = dbg_we_q;
    dbg_wreg_d    = dbg_wreg_q;
    dbg_data_d    = dbg_data_q;
    dbg_rreg_d    = dbg_rreg_q;
    wb_data_d     = wb_data_q;
    wait_cnt_d    = wait_cnt_q;

    // Second half of a step: re-halt after exactly one released cycle.
    // A step write always leads to ACK, so no new write can collide here.
    if (step_q) begin
      halt_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!i_wb_addr[ADDR_REGWIN_BIT]) begin
            state_d = ST_ACK;
            if (i_wb_we) begin
              if (ctrl_sel && i_wb_sel[0]) begin
                halt_d        = i_wb_data[CTRL_HALT];
                // Step only while halted and not combined with halt
                step_d        = halt_q && i_wb_data[CTRL_STEP]
                                && !i_wb_data[CTRL_HALT];
                cpu_reset_d   = i_wb_data[CTRL_RESET];
                clear_cache_d = i_wb_data[CTRL_CLRCACHE];
              end
            end else begin
              wb_data_d = ctrl_sel ? ctrl_word(halt_q, i_dbg_stall, i_break, i_dbg_cc)
                                   : '0;
            end
          end else if (i_wb_we) begin
            if (halt_q) begin
              dbg_we_d   = 1'b1;
              dbg_wreg_d = i_wb_addr[4:0];
              dbg_data_d = i_wb_data;
              state_d    = ST_WR;
            end else begin
              state_d = ST_ACK;
            end
          end else begin
            dbg_rreg_d = i_wb_addr[4:0];
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_RD;
          end
        end
      end

      ST_WR: begin
        if (!i_wb_cyc) begin
          dbg_we_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (!i_dbg_stall) begin
          dbg_we_d = 1'b0;
          state_d  = ST_ACK;
        end
      end

      ST_RD: begin
        if (!i_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == 2'd0) begin
          wb_data_d = i_dbg_reg;
          state_d   = ST_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      halt_q        <= OPT_START_HALTED;
      step_q        <= 1'b0;
      cpu_reset_q   <= 1'b0;
      clear_cache_q <= 1'b0;
      dbg_we_q      <= 1'b0;
      dbg_wreg_q    <= '0;
      dbg_data_q    <= '0;
      dbg_rreg_q    <= '0;
      wb_data_q     <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_d;
      step_q        <= step_d;
      cpu_reset_q   <= cpu_reset_d;
      clear_cache_q <= clear_cache_d;
      dbg_we_q      <= dbg_we_d;
      dbg_wreg_q    <= dbg_wreg_d;
      dbg_data_q    <= dbg_data_d;
      dbg_rreg_q    <= dbg_rreg_d;
      wb_data_q     <= wb_data_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign o_wb_stall    = (state_q != ST_IDLE);
  // Gated by cyc so an abandoned cycle never sees a late ack
  assign o_wb_ack      = (state_q == ST_ACK) && i_wb_cyc;
  assign o_wb_data     = wb_data_q;
  assign o_halt        = halt_q;
  assign o_clear_cache = clear_cache_q;
  assign o_cpu_reset   = cpu_reset_q;
  assign o_dbg_we      = dbg_we_q;
  assign o_dbg_wreg    = dbg_wreg_q;
  assign o_dbg_data    = dbg_data_q;
  assign o_dbg_rreg    = dbg_rreg_q;

endmodule

// File: tb/tb_zipdbg_slave.sv
// Self-checking bench for zipdbg_slave: directed bus transactions push
// expected ack data into a scoreboard; a negedge monitor pops on each ack.
module tb_zipdbg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, wb_we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        o_wb_stall, o_wb_ack;
  logic [31:0] o_wb_data;
  logic        o_halt, o_clear_cache, o_cpu_reset, o_dbg_we;
  logic [4:0]  o_dbg_wreg, o_dbg_rreg;
  logic [31:0] o_dbg_data;
  logic        dbg_stall;
  logic [31:0] dbg_reg;
  logic [2:0]  dbg_cc;
  logic        brk;

  zipdbg_slave #(.OPT_START_HALTED(1'b1), .OPT_DBGWAIT(1)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(wb_we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .o_halt(o_halt), .o_clear_cache(o_clear_cache), .o_cpu_reset(o_cpu_reset),
    .o_dbg_we(o_dbg_we), .o_dbg_wreg(o_dbg_wreg), .o_dbg_data(o_dbg_data),
    .o_dbg_rreg(o_dbg_rreg), .i_dbg_stall(dbg_stall), .i_dbg_reg(dbg_reg),
    .i_dbg_cc(dbg_cc), .i_break(brk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int we_cnt = 0, halt_low = 0, rst_cnt = 0, clr_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor and cycle counters, sampled mid-cycle
  always @(negedge clk) begin
    if (o_dbg_we)      we_cnt++;
    if (!o_halt)       halt_low++;
    if (o_cpu_reset)   rst_cnt++;
    if (o_clear_cache) clr_cnt++;
    if (o_wb_ack) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check("ack_data", o_wb_data, e.data);
      end
    end
  end

  task automatic issue(input logic we, input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; wb_we = we; addr = a; wdata = d; sel = s;
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (!o_wb_ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_wb_ack) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
    end
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  task automatic push(input logic c, input logic [31:0] d);
    exp_t e;
    e.chk  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b, b2;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; wb_we = 1'b0; addr = '0; wdata = '0;
    sel = '0; dbg_stall = 1'b0; dbg_reg = '0; dbg_cc = '0; brk = 1'b0;
    #1;
    check("rst_halt", 32'(o_halt), 32'd1);
    check("rst_ack", 32'(o_wb_ack), 32'd0);
    check("rst_stall", 32'(o_wb_stall), 32'd0);
    check("rst_dbg_we", 32'(o_dbg_we), 32'd0);
    check("rst_pulses", {30'd0, o_cpu_reset, o_clear_cache}, 32'd0);
    check("rst_wb_data", o_wb_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Control read while halted
    dbg_cc = 3'b101;
    push(1'b1, 32'h0000_0281);
    issue(1'b0, 6'h00, '0, 4'hF);
    wait_ack(lat);
    check("ctrl_rd_lat", 32'(lat), 32'd0);
    dbg_cc = '0;

    // Unmapped read
    push(1'b1, 32'h0);
    issue(1'b0, 6'h05, '0, 4'hF);
    wait_ack(lat);

    // Halted register write with stall high 3 cycles; sel ignored
    dbg_stall = 1'b1;
    b = we_cnt;
    push(1'b0, '0);
    issue(1'b1, 6'h23, 32'hDEAD_BEEF, 4'h0);
    check("wr_we", 32'(o_dbg_we), 32'd1);
    check("wr_wreg", 32'(o_dbg_wreg), 32'd3);
    check("wr_data", o_dbg_data, 32'hDEAD_BEEF);
    repeat (3) begin @(posedge clk); #1; end
    check("wr_held", {30'd0, o_dbg_we, o_wb_ack}, 32'd2);
    dbg_stall = 1'b0;
    wait_ack(lat);
    check("wr_ack_lat", 32'(lat), 32'd1);
    check("wr_we_cycles", 32'(we_cnt - b), 32'd4);

    // Register read, one wait cycle
    dbg_reg = 32'h1234_5678;
    push(1'b1, 32'h1234_5678);
    issue(1'b0, 6'h2F, '0, 4'hF);
    check("rd_rreg", 32'(o_dbg_rreg), 32'd15);
    check("rd_stall", 32'(o_wb_stall), 32'd1);
    wait_ack(lat);
    check("rd_ack_lat", 32'(lat), 32'd1);
    dbg_reg = 32'hFFFF_FFFF;

    // Step while halted; read data must still hold the last read
    b = halt_low;
    push(1'b1, 32'h1234_5678);
    issue(1'b1, 6'h00, 32'h2, 4'hF);
    check("step_release", 32'(o_halt), 32'd0);
    wait_ack(lat);
    check("step_rehalt", 32'(o_halt), 32'd1);
    check("step_low_cycles", 32'(halt_low - b), 32'd1);

    // Step with the core stalled
    dbg_stall = 1'b1;
    b = halt_low;
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'h2, 4'hF);
    wait_ack(lat);
    check("step_stall_low_cycles", 32'(halt_low - b), 32'd1);
    dbg_stall = 1'b0;

    // Reset and clear-cache pulses, staying halted
    b = rst_cnt; b2 = clr_cnt;
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'hD, 4'hF);
    check("pulses_on", {30'd0, o_cpu_reset, o_clear_cache}, 32'd3);
    wait_ack(lat);
    check("cpu_reset_cycles", 32'(rst_cnt - b), 32'd1);
    check("clear_cache_cycles", 32'(clr_cnt - b2), 32'd1);
    check("pulses_halt", 32'(o_halt), 32'd1);

    // Step + halt together: no release
    b = halt_low;
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'h3, 4'hF);
    wait_ack(lat);
    @(posedge clk); #1;
    check("step_halt_low_cycles", 32'(halt_low - b), 32'd0);

    // sel[0]=0 control write is ignored
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'h0, 4'hE);
    wait_ack(lat);
    check("sel0_ignored", 32'(o_halt), 32'd1);

    // Release halt
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'h0, 4'h1);
    wait_ack(lat);
    check("unhalt", 32'(o_halt), 32'd0);

    // Step while running: ignored
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'h2, 4'hF);
    wait_ack(lat);
    @(posedge clk); #1;
    check("step_running", 32'(o_halt), 32'd0);

    // Register write while running: acked, no write strobe
    b = we_cnt;
    push(1'b0, '0);
    issue(1'b1, 6'h25, 32'h5555_AAAA, 4'hF);
    wait_ack(lat);
    check("run_wr_lat", 32'(lat), 32'd0);
    check("run_wr_no_we", 32'(we_cnt - b), 32'd0);

    // Control read with status bits
    dbg_stall = 1'b1; brk = 1'b1; dbg_cc = 3'b010;
    push(1'b1, 32'h0000_0160);
    issue(1'b0, 6'h00, '0, 4'hF);
    wait_ack(lat);
    dbg_stall = 1'b0; brk = 1'b0; dbg_cc = '0;

    // Halt, then abandon a register write mid-WR
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'h1, 4'hF);
    wait_ack(lat);
    dbg_stall = 1'b1;
    issue(1'b1, 6'h21, 32'hA5A5_A5A5, 4'hF);
    check("abort_we_on", 32'(o_dbg_we), 32'd1);
    cyc = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {29'd0, o_dbg_we, o_wb_stall, o_wb_ack}, 32'd0);
    dbg_stall = 1'b0;
    @(posedge clk); #1;

    // Release halt, then reset asynchronously mid-RD
    push(1'b0, '0);
    issue(1'b1, 6'h00, 32'h0, 4'hF);
    wait_ack(lat);
    issue(1'b0, 6'h2A, '0, 4'hF);
    check("rd_before_rst", {31'd0, o_wb_stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_halt", 32'(o_halt), 32'd1);
    check("async_rst_idle", {29'd0, o_dbg_we, o_wb_stall, o_wb_ack}, 32'd0);
    check("async_rst_rreg", 32'(o_dbg_rreg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;

    // Recovery read
    push(1'b1, 32'h0000_0001);
    issue(1'b0, 6'h00, '0, 4'hF);
    wait_ack(lat);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
